branch_resolve_bht: RTL and testbench
=====================================

# branch_resolve_bht

Branch resolution and direction-prediction unit for the pipelined RV32I core. It consumes the `brc` comparator flags for the branch in EX, resolves BEQ/BNE/BLT/BGE/BLTU/BGEU, and trains a table of 2-bit saturating counters. It serves direction predictions to decode and issues a registered redirect on mispredict. It also drives the comparator mode select and keeps branch and mispredict performance counters.

## Interface
- `BHT_ENTRIES`, 64: number of counters; power of 2, at least 2. `IDX_W = $clog2(BHT_ENTRIES)`.
- `i_clk`  in  1  clock, rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_pred_pc`  in  32  PC of the instruction in decode to predict.
- `o_pred_taken`  out  1  combinational prediction: MSB of `bht[i_pred_pc[IDX_W+1:2]]`.
- `i_ex_valid`  in  1  EX holds a conditional-branch instruction.
- `i_ex_pc`  in  32  PC of the EX branch.
- `i_ex_funct3`  in  3  branch funct3.
- `i_ex_pred_taken`  in  1  prediction carried down with the instruction.
- `i_ex_target`  in  32  computed branch target.
- `i_br_less`, `i_br_equal`  in  1 each  comparator flags.
- `o_br_un`  out  1  comparator mode, `brc` encoding: 1 = signed, 0 = unsigned.
- `o_taken`  out  1  combinational resolved direction.
- `o_redirect_valid`  out  1  registered mispredict redirect.
- `o_redirect_pc`  out  32  registered redirect address.
- `o_br_count`  out  32  number of resolved branches.
- `o_mispred_count`  out  32  number of mispredicted branches.

## Operation
- `o_br_un` depends only on `i_ex_funct3`:
  - 1 for 100 and 101.
  - 0 for 110 and 111.
  - 0 otherwise.
- Branch-valid: `bv = i_ex_valid & funct3 ∈ {000,001,100,101,110,111}`. Funct3 010 and 011 give bv = 0.
- Resolved direction:
  - 000 taken = equal
  - 001 taken = ~equal
  - 100 and 110: taken = less
  - 101 and 111: taken = ~less
  - `o_taken = bv & taken`.
- Mispredict: `mp = bv & (taken != i_ex_pred_taken)`.
- Fix-up PC: `i_ex_target` if taken, else `i_ex_pc + 32'd4` (modulo 2^32).
- BHT update on each clock with bv = 1, at index `i_ex_pc[IDX_W+1:2]`:
  - taken: counter + 1, saturating at 2'b11.
  - not taken: counter − 1, saturating at 2'b00.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = MSB.
- Redirect register: `o_redirect_valid <= mp`, and `o_redirect_pc` loads the fix-up PC when mp = 1, otherwise holds its value.
- Perf counters:
  - `o_br_count` increments on bv.
  - `o_mispred_count` increments on mp.
  - Both saturate at 32'hFFFF_FFFF; they do not wrap.
- PC bits [1:0] and the bits above IDX_W+1 are ignored for indexing. Aliasing is permitted.

## Timing
- Reset (i_reset high at a rising edge):
  - all BHT entries ← 2'b01.
  - `o_redirect_valid` ← 0, `o_redirect_pc` ← 0.
  - both perf counters ← 0.
  - Reset overrides any same-cycle update.
- After reset, `o_pred_taken` reads 0 for every PC.
- `o_br_un`, `o_taken` and `o_pred_taken` are combinational, with zero latency.
- Redirect latency is 1 cycle: a mispredict in EX in cycle N gives `o_redirect_valid` = 1 during cycle N+1 only. This is a single-cycle pulse per mispredict; back-to-back mispredicts give back-to-back pulses.
- The pipeline flushes the instructions younger than the branch on `o_redirect_valid`. The unit has no stall input.
- Read/write collision (`i_pred_pc` and `i_ex_pc` map to the same index in one cycle): `o_pred_taken` returns the pre-update value. There is no bypass.
- Reset asserted mid-stream drops any pending redirect: `o_redirect_valid` is 0 in the cycle after reset.
- Comparator flags are don't-care when bv = 0. In that case there is no state change.

## Test plan
- **Reset/default:** assert i_reset for 2 cycles, sweep `i_pred_pc` 0x0 to 0xFC.
  - `o_pred_taken` = 0 for all PCs.
  - `o_redirect_valid` = 0.
  - both counters = 0.
- **Funct3 decode:** for funct3 000/001/100/101/110/111 with (less, equal) = (0,1), (1,0), (0,0):
  - `o_taken` matches the rules above.
  - `o_br_un` = 1 only for 100/101.
  - funct3 010 gives `o_taken` = 0, no update and no count.
- **Training/saturation:** pc 0x40 taken on 3 consecutive branches.
  - `o_pred_taken(0x40)` goes 0, 1, 1.
  - 3 further not-taken updates give 1, 1, 0.
  - Counter walk: 01→10→11→11, then 11→10→01→00.
- **Mispredict redirect:**
  - pc 0x100, pred 0, taken, target 0x200: next cycle redirect_valid = 1, pc = 0x200, for exactly one cycle.
  - pc 0xFFFF_FFFC, pred 1, not taken: redirect pc = 0x0000_0000.
- **Collision/aliasing:** with BHT_ENTRIES = 64, update 0x0 taken while predicting 0x100 in the same cycle.
  - Prediction shows the old value (0).
  - The following cycle shows 1.
- **Counters/reset mid-op:** preload counters to 0xFFFF_FFFE via force, then run 3 mispredicts.
  - Both counters saturate at 0xFFFF_FFFF.
  - Assert reset in the cycle a redirect is due: `o_redirect_valid` stays 0 and the counters read 0.

Source files
------------

// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - RV32I branch resolution, 2-bit counter BHT, mispredict redirect and perf counters
module branch_resolve_bht #(
    parameter int BHT_ENTRIES = 64
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pred_pc,
    output logic        o_pred_taken,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_pc,
    input  logic [2:0]  i_ex_funct3,
    input  logic        i_ex_pred_taken,
    input  logic [31:0] i_ex_target,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_br_un,
    output logic        o_taken,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_br_count,
    output logic [31:0] o_mispred_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       r_bht [BHT_ENTRIES];
    logic             r_redirect_valid;
    logic [31:0]      r_redirect_pc;
    logic [31:0]      r_br_count;
    logic [31:0]      r_mispred_count;

    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_f3_ok;
    logic             w_dir;
    logic             w_br_un;
    logic             w_bv;
    logic             w_mp;
    logic [31:0]      w_fix_pc;
    logic [1:0]       w_ctr;
    logic [1:0]       w_ctr_next;
    logic             w_unused;

    assign w_pred_idx = i_pred_pc[IDX_W+1:2];
    assign w_ex_idx   = i_ex_pc[IDX_W+1:2];
    assign w_unused   = ^{i_pred_pc[31:IDX_W+2], i_pred_pc[1:0]};

    always_comb begin
        w_f3_ok = 1'b0;
        w_dir   = 1'b0;
        w_br_un = 1'b0;
        case (i_ex_funct3)
            3'b000: begin w_f3_ok = 1'b1; w_dir = i_br_equal;  end
            3'b001: begin w_f3_ok = 1'b1; w_dir = ~i_br_equal; end
            3'b100: begin w_f3_ok = 1'b1; w_dir = i_br_less;  w_br_un = 1'b1; end
            3'b101: begin w_f3_ok = 1'b1; w_dir = ~i_br_less; w_br_un = 1'b1; end
            3'b110: begin w_f3_ok = 1'b1; w_dir = i_br_less;  end
            3'b111: begin w_f3_ok = 1'b1; w_dir = ~i_br_less; end
            default: ;
        endcase
    end

    assign w_bv     = i_ex_valid & w_f3_ok;
    assign w_mp     = w_bv & (w_dir != i_ex_pred_taken);
    assign w_fix_pc = w_dir ? i_ex_target : (i_ex_pc + 32'd4);

    assign o_br_un      = w_br_un;
    assign o_taken      = w_bv & w_dir;
    // Read port sees the pre-update counter even when indices collide.
    assign o_pred_taken = r_bht[w_pred_idx][1];

    always_comb begin
        w_ctr      = r_bht[w_ex_idx];
        w_ctr_next = w_ctr;
        if (w_dir) begin
            if (w_ctr != 2'b11) w_ctr_next = w_ctr + 2'b01;
        end else begin
            if (w_ctr != 2'b00) w_ctr_next = w_ctr - 2'b01;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
        end else if (w_bv) begin
            r_bht[w_ex_idx] <= w_ctr_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_br_count       <= 32'd0;
            r_mispred_count  <= 32'd0;
        end else begin
            r_redirect_valid <= w_mp;
            if (w_mp) r_redirect_pc <= w_fix_pc;
            if (w_bv && r_br_count != 32'hFFFF_FFFF) r_br_count <= r_br_count + 32'd1;
            if (w_mp && r_mispred_count != 32'hFFFF_FFFF) r_mispred_count <= r_mispred_count + 32'd1;
        end
    end

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_br_count       = r_br_count;
    assign o_mispred_count  = r_mispred_count;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb/tb_branch_resolve_bht.sv - directed self-checking bench for branch_resolve_bht
`timescale 1ns/1ps
module tb_branch_resolve_bht;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_pred_pc;
    logic        o_pred_taken;
    logic        i_ex_valid;
    logic [31:0] i_ex_pc;
    logic [2:0]  i_ex_funct3;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_target;
    logic        i_br_less;
    logic        i_br_equal;
    logic        o_br_un;
    logic        o_taken;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_br_count;
    logic [31:0] o_mispred_count;

    int n_vec = 0;
    int n_err = 0;

    branch_resolve_bht #(.BHT_ENTRIES(64)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_pred_pc       (i_pred_pc),
        .o_pred_taken    (o_pred_taken),
        .i_ex_valid      (i_ex_valid),
        .i_ex_pc         (i_ex_pc),
        .i_ex_funct3     (i_ex_funct3),
        .i_ex_pred_taken (i_ex_pred_taken),
        .i_ex_target     (i_ex_target),
        .i_br_less       (i_br_less),
        .i_br_equal      (i_br_equal),
        .o_br_un         (o_br_un),
        .o_taken         (o_taken),
        .o_redirect_valid(o_redirect_valid),
        .o_redirect_pc   (o_redirect_pc),
        .o_br_count      (o_br_count),
        .o_mispred_count (o_mispred_count)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        i_ex_valid = 1'b0; i_ex_pc = 32'd0; i_ex_funct3 = 3'b000;
        i_ex_pred_taken = 1'b0; i_ex_target = 32'd0;
        i_br_less = 1'b0; i_br_equal = 1'b0; i_pred_pc = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        idle_inputs();
        i_reset = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // One branch on pc through a single rising edge; equal drives the BEQ outcome.
    task automatic beq(input logic [31:0] pc, input logic tk, input logic pred, input logic [31:0] tgt);
        @(negedge i_clk);
        i_ex_valid = 1'b1; i_ex_pc = pc; i_ex_funct3 = 3'b000;
        i_br_equal = tk; i_br_less = 1'b0; i_ex_pred_taken = pred; i_ex_target = tgt;
        @(posedge i_clk);
        #1;
        i_ex_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int a = 0; a <= 32'hFC; a += 4) begin
            i_pred_pc = a;
            #1;
            n_vec++;
            if (o_pred_taken !== 1'b0) begin
                n_err++; $display("FAIL reset_pred pc=%h got %b required 0", a, o_pred_taken);
            end
        end
        n_vec++;
        if (o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv got %b required 0", o_redirect_valid); end
        n_vec++;
        if (o_redirect_pc !== 32'd0) begin n_err++; $display("FAIL reset_rpc got %h required 0", o_redirect_pc); end
        n_vec++;
        if (o_br_count !== 32'd0) begin n_err++; $display("FAIL reset_brcnt got %h required 0", o_br_count); end
        n_vec++;
        if (o_mispred_count !== 32'd0) begin n_err++; $display("FAIL reset_mpcnt got %h required 0", o_mispred_count); end
    endtask

    task automatic test_decode();
        logic [2:0] f3s [6];
        logic [2:0] exp_tk [6];
        logic [5:0] exp_un;
        logic [1:0] flags [3];
        f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        // bit2..0 = expected taken for (less,equal) = (0,1), (1,0), (0,0)
        exp_tk = '{3'b100, 3'b011, 3'b010, 3'b101, 3'b010, 3'b101};
        exp_un = 6'b001100;
        flags = '{2'b01, 2'b10, 2'b00};
        @(negedge i_clk);
        i_ex_valid = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 3; k++) begin
                i_ex_funct3 = f3s[f];
                {i_br_less, i_br_equal} = flags[k];
                #0.2;
                n_vec++;
                if (o_taken !== exp_tk[f][2-k]) begin
                    n_err++; $display("FAIL decode_taken f3=%b lt/eq=%b got %b required %b", f3s[f], flags[k], o_taken, exp_tk[f][2-k]);
                end
            end
            n_vec++;
            if (o_br_un !== exp_un[5-f]) begin
                n_err++; $display("FAIL decode_br_un f3=%b got %b required %b", f3s[f], o_br_un, exp_un[5-f]);
            end
        end
        i_ex_valid = 1'b0; i_ex_funct3 = 3'b000; i_br_equal = 1'b1;
        #0.2;
        n_vec++;
        if (o_taken !== 1'b0) begin n_err++; $display("FAIL decode_invalid got %b required 0", o_taken); end
        do_reset();
        // funct3 010: no direction, no BHT update, no count, no redirect
        i_ex_valid = 1'b1; i_ex_funct3 = 3'b010; i_br_less = 1'b1; i_br_equal = 1'b1;
        i_ex_pc = 32'h40; i_pred_pc = 32'h40; i_ex_pred_taken = 1'b1; i_ex_target = 32'h80;
        #1;
        n_vec++;
        if (o_taken !== 1'b0) begin n_err++; $display("FAIL f3_010_taken got %b required 0", o_taken); end
        n_vec++;
        if (o_br_un !== 1'b0) begin n_err++; $display("FAIL f3_010_br_un got %b required 0", o_br_un); end
        @(posedge i_clk); #1;
        i_ex_funct3 = 3'b011; i_br_less = 1'b0; i_br_equal = 1'b0;
        @(posedge i_clk); #1;
        i_ex_valid = 1'b0;
        n_vec++;
        if (o_br_count !== 32'd0) begin n_err++; $display("FAIL f3_010_count got %h required 0", o_br_count); end
        n_vec++;
        if (o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL f3_010_redirect got %b required 0", o_redirect_valid); end
        n_vec++;
        if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL f3_010_bht got %b required 0", o_pred_taken); end
    endtask

    task automatic test_training();
        logic [2:0] exp_t;
        logic [3:0] exp_n;
        do_reset();
        i_pred_pc = 32'h40;
        exp_t = 3'b011;       // before each taken: 0,1,1
        for (int s = 0; s < 3; s++) begin
            #1;
            n_vec++;
            if (o_pred_taken !== exp_t[2-s]) begin
                n_err++; $display("FAIL train_up step=%0d got %b required %b", s, o_pred_taken, exp_t[2-s]);
            end
            beq(32'h40, 1'b1, o_pred_taken, 32'h0);
        end
        exp_n = 4'b1100;      // before each not-taken: 1,1,0,0
        for (int s = 0; s < 4; s++) begin
            #1;
            n_vec++;
            if (o_pred_taken !== exp_n[3-s]) begin
                n_err++; $display("FAIL train_down step=%0d got %b required %b", s, o_pred_taken, exp_n[3-s]);
            end
            beq(32'h40, 1'b0, o_pred_taken, 32'h0);
        end
        n_vec++;
        if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL train_sat_low got %b required 0", o_pred_taken); end
        beq(32'h40, 1'b1, 1'b0, 32'h0);
        n_vec++;
        if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL train_sat_low_up1 got %b required 0", o_pred_taken); end
        beq(32'h40, 1'b1, 1'b0, 32'h0);
        n_vec++;
        if (o_pred_taken !== 1'b1) begin n_err++; $display("FAIL train_sat_low_up2 got %b required 1", o_pred_taken); end
    endtask

    task automatic test_redirect();
        do_reset();
        beq(32'h100, 1'b1, 1'b0, 32'h200);
        n_vec++;
        if (o_redirect_valid !== 1'b1) begin n_err++; $display("FAIL redir_valid got %b required 1", o_redirect_valid); end
        n_vec++;
        if (o_redirect_pc !== 32'h200) begin n_err++; $display("FAIL redir_pc got %h required 00000200", o_redirect_pc); end
        @(posedge i_clk); #1;
        n_vec++;
        if (o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL redir_pulse got %b required 0", o_redirect_valid); end
        n_vec++;
        if (o_redirect_pc !== 32'h200) begin n_err++; $display("FAIL redir_hold got %h required 00000200", o_redirect_pc); end
        beq(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234);
        n_vec++;
        if (o_redirect_valid !== 1'b1) begin n_err++; $display("FAIL redir_wrap_valid got %b required 1", o_redirect_valid); end
        n_vec++;
        if (o_redirect_pc !== 32'h0) begin n_err++; $display("FAIL redir_wrap_pc got %h required 00000000", o_redirect_pc); end
        beq(32'h300, 1'b1, 1'b0, 32'h400);
        beq(32'h500, 1'b0, 1'b1, 32'h600);
        n_vec++;
        if (o_redirect_valid !== 1'b1) begin n_err++; $display("FAIL redir_b2b_valid got %b required 1", o_redirect_valid); end
        n_vec++;
        if (o_redirect_pc !== 32'h504) begin n_err++; $display("FAIL redir_b2b_pc got %h required 00000504", o_redirect_pc); end
        beq(32'h700, 1'b1, 1'b1, 32'h800);
        n_vec++;
        if (o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL redir_correct got %b required 0", o_redirect_valid); end
        n_vec++;
        if (o_redirect_pc !== 32'h504) begin n_err++; $display("FAIL redir_correct_hold got %h required 00000504", o_redirect_pc); end
        n_vec++;
        if (o_br_count !== 32'd5) begin n_err++; $display("FAIL redir_brcnt got %0d required 5", o_br_count); end
        n_vec++;
        if (o_mispred_count !== 32'd4) begin n_err++; $display("FAIL redir_mpcnt got %0d required 4", o_mispred_count); end
    endtask

    task automatic test_collision();
        do_reset();
        i_pred_pc = 32'h100;
        i_ex_valid = 1'b1; i_ex_pc = 32'h0; i_ex_funct3 = 3'b000;
        i_br_equal = 1'b1; i_ex_pred_taken = 1'b0; i_ex_target = 32'h20;
        #1;
        n_vec++;
        if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL collide_old got %b required 0", o_pred_taken); end
        @(posedge i_clk); #1;
        i_ex_valid = 1'b0;
        #1;
        n_vec++;
        if (o_pred_taken !== 1'b1) begin n_err++; $display("FAIL collide_new got %b required 1", o_pred_taken); end
    endtask

    task automatic test_counters();
        do_reset();
        @(negedge i_clk);
        force dut.r_br_count = 32'hFFFF_FFFE;
        force dut.r_mispred_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_br_count;
        release dut.r_mispred_count;
        beq(32'h40, 1'b0, 1'b1, 32'h0);
        n_vec++;
        if (o_br_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cnt_br_first got %h required ffffffff", o_br_count); end
        beq(32'h40, 1'b0, 1'b1, 32'h0);
        beq(32'h40, 1'b0, 1'b1, 32'h0);
        n_vec++;
        if (o_br_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cnt_br_sat got %h required ffffffff", o_br_count); end
        n_vec++;
        if (o_mispred_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cnt_mp_sat got %h required ffffffff", o_mispred_count); end
        n_vec++;
        if (o_redirect_valid !== 1'b1) begin n_err++; $display("FAIL cnt_pre_rst_rv got %b required 1", o_redirect_valid); end
        // mispredict alongside reset at the same edge
        @(negedge i_clk);
        i_reset = 1'b1;
        i_ex_valid = 1'b1; i_ex_pc = 32'h80; i_ex_funct3 = 3'b000;
        i_br_equal = 1'b1; i_ex_pred_taken = 1'b0; i_ex_target = 32'h90;
        @(posedge i_clk); #1;
        i_reset = 1'b0; i_ex_valid = 1'b0;
        n_vec++;
        if (o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_rv got %b required 0", o_redirect_valid); end
        n_vec++;
        if (o_redirect_pc !== 32'h0) begin n_err++; $display("FAIL rst_mid_rpc got %h required 0", o_redirect_pc); end
        n_vec++;
        if (o_br_count !== 32'd0) begin n_err++; $display("FAIL rst_mid_brcnt got %h required 0", o_br_count); end
        n_vec++;
        if (o_mispred_count !== 32'd0) begin n_err++; $display("FAIL rst_mid_mpcnt got %h required 0", o_mispred_count); end
        i_pred_pc = 32'h80;
        #1;
        n_vec++;
        if (o_pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_mid_bht got %b required 0", o_pred_taken); end
    endtask

    initial begin
        i_reset = 1'b1;
        idle_inputs();
        test_reset();
        test_decode();
        test_training();
        test_redirect();
        test_collision();
        test_counters();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
